// File: rtl/match_scan_ctrl.sv
// Multi-match iterator: accepts a match window and emits each set-bit index over a valid/ready handshake.
// Optional macro SCAN_REVERSE_EN emits indices highest-first instead of lowest-first.
module match_scan_ctrl #(
    parameter int WINSIZE = 200,
    parameter int IDXW    = $clog2(WINSIZE),
    parameter int CNTW    = $clog2(WINSIZE + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WINSIZE-1:0] in_vec,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [IDXW-1:0]    out_idx,
    output logic               out_last,
    output logic               done,
    output logic [CNTW-1:0]    count,
    output logic               busy
);

    typedef enum logic {
        IDLE,
        SCAN
    } state_t;

    localparam logic [WINSIZE-1:0] ONE = WINSIZE'(1);

    state_t             state_q;
    logic [WINSIZE-1:0] vec_q, vec_d;
    logic [CNTW-1:0]    count_q, count_d;
    logic               done_q;
    logic [IDXW-1:0]    enc_idx;
    logic               single_bit;

`ifdef SCAN_REVERSE_EN
    // Bit-reversing the input, taking the lowest set bit and mapping back
    // is the same as selecting the highest set bit directly.
    function automatic logic [IDXW-1:0] encode(input logic [WINSIZE-1:0] v);
        logic [IDXW-1:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < WINSIZE; i++) begin
            if (v[i]) idx = IDXW'(i);
        end
        return idx;
    endfunction
`else
    function automatic logic [IDXW-1:0] encode(input logic [WINSIZE-1:0] v);
        logic [IDXW-1:0] idx;
        logic            found;
        idx   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < WINSIZE; i++) begin
            if (v[i] && !found) begin
                idx   = IDXW'(i);
                found = 1'b1;
            end
        end
        return idx;
    endfunction
`endif

    always_comb begin
        enc_idx    = encode(vec_q);
        single_bit = ((vec_q & (vec_q - ONE)) == '0);
        vec_d      = vec_q & ~(ONE << enc_idx);
        count_d    = count_q + CNTW'(1);
    end

    // flush sits above both handshakes so neither can take effect in its cycle
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state_q <= IDLE;
            vec_q   <= '0;
            count_q <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        count_q <= '0;
                        if (in_vec == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            vec_q   <= in_vec;
                            state_q <= SCAN;
                        end
                    end
                end
                SCAN: begin
                    if (out_ready) begin
                        vec_q   <= vec_d;
                        count_q <= count_d;
                        if (single_bit) begin
                            state_q <= IDLE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        busy      = (state_q == SCAN);
        out_valid = (state_q == SCAN);
        out_idx   = (state_q == SCAN) ? enc_idx : '0;
        out_last  = (state_q == SCAN) && single_bit;
        done      = done_q;
        count     = count_q;
    end

endmodule

// File: tb/tb_match_scan_ctrl.sv
// Self-checking bench for match_scan_ctrl: directed scenarios plus randomized windows
// checked against a queue-based model of the expected emission order.
module tb_match_scan_ctrl;

    localparam int WINSIZE = 200;
    localparam int IDXW    = $clog2(WINSIZE);
    localparam int CNTW    = $clog2(WINSIZE + 1);

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic [WINSIZE-1:0] in_vec;
    logic               flush;
    logic               out_valid;
    logic               out_ready;
    logic [IDXW-1:0]    out_idx;
    logic               out_last;
    logic               done;
    logic [CNTW-1:0]    count;
    logic               busy;

    int unsigned total  = 0;
    int unsigned passed = 0;

    always #5 clk = ~clk;

    match_scan_ctrl #(
        .WINSIZE(WINSIZE),
        .IDXW   (IDXW),
        .CNTW   (CNTW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_vec   (in_vec),
        .flush    (flush),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_idx  (out_idx),
        .out_last (out_last),
        .done     (done),
        .count    (count),
        .busy     (busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    // Feeds one window and drains it. mode 0: out_ready always high,
    // mode 1: out_ready pattern 1-0-0-1-1 repeating, mode 2: random out_ready.
    task automatic run_window(input logic [WINSIZE-1:0] v, input int mode, input string tag);
        int              q[$];
        int              n;
        int              cyc;
        logic            rdy;
        logic [4:0]      pat;
        logic [IDXW+4:0] obs, expv;
        logic [CNTW+3:0] fobs, fexp;
        pat = 5'b10011;
        q   = {};
        for (int i = 0; i < WINSIZE; i++) begin
            if (v[i]) begin
`ifdef SCAN_REVERSE_EN
                q.push_front(i);
`else
                q.push_back(i);
`endif
            end
        end
        n = q.size();
        total++;
        if (in_ready !== 1'b1)
            $display("FAIL %s accept_ready: in_ready=%b expected 1", tag, in_ready);
        else passed++;
        in_valid = 1'b1;
        in_vec   = v;
        step();
        in_valid = 1'b0;
        in_vec   = '0;
        cyc      = 0;
        while (q.size() > 0 && cyc < 4 * WINSIZE + 8) begin
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = pat[4 - (cyc % 5)];
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            out_ready = rdy;
            expv = {1'b1, IDXW'(q[0]), (q.size() == 1), 1'b0, 1'b0, 1'b1};
            obs  = {out_valid, out_idx, out_last, done, in_ready, busy};
            total++;
            if (obs !== expv)
                $display("FAIL %s emit[%0d]: {valid,idx,last,done,in_ready,busy}=%h expected %h",
                         tag, n - q.size(), obs, expv);
            else passed++;
            if (rdy) void'(q.pop_front());
            step();
            cyc++;
        end
        out_ready = 1'b0;
        if (q.size() > 0) begin
            total++;
            $display("FAIL %s timeout: %0d indices left, expected 0", tag, q.size());
            do_reset();
            return;
        end
        fobs = {out_valid, done, count, in_ready, busy};
        fexp = {1'b0, 1'b1, CNTW'(n), 1'b1, 1'b0};
        total++;
        if (fobs !== fexp)
            $display("FAIL %s drained: {valid,done,count,in_ready,busy}=%h expected %h", tag, fobs, fexp);
        else passed++;
    endtask

    task automatic test_reset();
        logic [IDXW+CNTW+4:0] obs;
        do_reset();
        obs = {in_ready, out_valid, out_idx, out_last, done, count, busy};
        total++;
        if (obs !== {1'b1, 1'b0, IDXW'(0), 1'b0, 1'b0, CNTW'(0), 1'b0})
            $display("FAIL reset_state: got %h expected ready=1 and all others 0", obs);
        else passed++;
    endtask

    task automatic test_directed();
        logic [WINSIZE-1:0] v;
        v = '0;
        v[3] = 1'b1;
        v[77] = 1'b1;
        v[199] = 1'b1;
        run_window(v, 0, "three_bits");
        run_window(v, 1, "three_bits_stall");
    endtask

    task automatic test_zero();
        run_window('0, 0, "zero_vec");
        step();
        total++;
        if ({done, in_ready, out_valid} !== 3'b010)
            $display("FAIL zero_after: {done,in_ready,valid}=%b expected 010", {done, in_ready, out_valid});
        else passed++;
    endtask

    task automatic test_back_to_back();
        logic [WINSIZE-1:0] a, b;
        a = '0;
        a[0] = 1'b1;
        b = '0;
        b[WINSIZE-1] = 1'b1;
        run_window(a, 0, "b2b_first");
        run_window(b, 0, "b2b_second");
    endtask

    task automatic test_flush();
        logic [IDXW+CNTW+4:0] obs;
        int                   e;
        in_valid = 1'b1;
        in_vec   = '1;
        step();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
`ifdef SCAN_REVERSE_EN
            e = WINSIZE - 1 - i;
`else
            e = i;
`endif
            total++;
            if ({out_valid, out_idx} !== {1'b1, IDXW'(e)})
                $display("FAIL flush_pre[%0d]: valid=%b idx=%0d expected 1 %0d", i, out_valid, out_idx, e);
            else passed++;
            step();
        end
        flush = 1'b1;
        step();
        flush     = 1'b0;
        out_ready = 1'b0;
        obs = {in_ready, out_valid, out_idx, out_last, done, count, busy};
        total++;
        if (obs !== {1'b1, 1'b0, IDXW'(0), 1'b0, 1'b0, CNTW'(0), 1'b0})
            $display("FAIL flush_state: got %h expected idle with count 0", obs);
        else passed++;
        step();
        total++;
        if ({done, out_valid} !== 2'b00)
            $display("FAIL flush_no_done: {done,valid}=%b expected 00", {done, out_valid});
        else passed++;
        in_valid = 1'b1;
        in_vec   = '0;
        in_vec[5] = 1'b1;
        flush    = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        in_vec   = '0;
        total++;
        if ({in_ready, out_valid, done, busy} !== 4'b1000)
            $display("FAIL flush_over_accept: {in_ready,valid,done,busy}=%b expected 1000",
                     {in_ready, out_valid, done, busy});
        else passed++;
        run_window(WINSIZE'(64'h0000_8000_0000_0401), 0, "after_flush");
    endtask

    task automatic test_reset_mid_scan();
        logic [IDXW+CNTW+4:0] obs;
        in_valid = 1'b1;
        in_vec   = WINSIZE'(32'hF0F0);
        step();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        step();
        out_ready = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        obs = {in_ready, out_valid, out_idx, out_last, done, count, busy};
        total++;
        if (obs !== {1'b1, 1'b0, IDXW'(0), 1'b0, 1'b0, CNTW'(0), 1'b0})
            $display("FAIL rst_mid_scan: got %h expected reset state", obs);
        else passed++;
        step();
        total++;
        if ({done, out_valid} !== 2'b00)
            $display("FAIL rst_no_done: {done,valid}=%b expected 00", {done, out_valid});
        else passed++;
    endtask

    task automatic test_random();
        logic [WINSIZE-1:0] v;
        int unsigned        k;
        for (int w = 0; w < 25; w++) begin
            k = $urandom_range(0, 40);
            v = '0;
            for (int i = 0; i < WINSIZE; i++) begin
                if (k != 0 && $urandom_range(0, k) == 0) v[i] = 1'b1;
            end
            run_window(v, 2, $sformatf("random_%0d", w));
        end
    endtask

    initial begin
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_vec    = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        #2;
        test_reset();
        test_directed();
        test_zero();
        test_back_to_back();
        test_flush();
        test_reset_mid_scan();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/match_scan_ctrl.md
# match_scan_ctrl

Sequential scheduler that accepts a WINSIZE-bit match window and emits the index of every set bit, one per handshake, using the lowest-set-bit priority encoder as its datapath. It sits between the window comparator stage, which produces one-hot/multi-hot match vectors, and the downstream consumer that processes match positions. It turns the single-index combinational encoder into a full multi-match iterator with valid/ready flow control.

## Interface

Parameters:
- WINSIZE, 200, width of the match window in bits.
- IDXW, $clog2(WINSIZE), width of an emitted index.
- CNTW, $clog2(WINSIZE+1), width of the per-window match count.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  window vector available.
- in_ready  output  1  block can accept a window; high only in IDLE.
- in_vec  input  WINSIZE  match vector.
- flush  input  1  synchronous abort of the current window.
- out_valid  output  1  out_idx holds a valid match index.
- out_ready  input  1  consumer accepts out_idx.
- out_idx  output  IDXW  index of the current set bit.
- out_last  output  1  current index is the final set bit of the window.
- done  output  1  one-cycle pulse: window fully drained.
- count  output  CNTW  number of indices emitted for the most recent window.
- busy  output  1  high in SCAN.

## Operation

- Internal: vec_reg[WINSIZE], count register, state in {IDLE, SCAN}; encoder instance driven by vec_reg.
- IDLE: in_ready=1. On in_valid&&in_ready: count<=0; if in_vec!=0, vec_reg<=in_vec, go SCAN; if in_vec==0, stay IDLE and pulse done next cycle with count=0.
- SCAN: out_valid=1, out_idx=encoder(vec_reg), out_last=((vec_reg & (vec_reg-1))==0). On out_valid&&out_ready: clear bit out_idx in vec_reg, count<=count+1. If out_last: go IDLE, pulse done next cycle.
- Outside SCAN: out_valid=0, out_idx=0, out_last=0.
- flush (any state): vec_reg<=0, count<=0, state<=IDLE, done<=0; overrides simultaneous input and output handshakes (neither takes effect).
- count holds the value of the last completed window until the next accepted window or flush.
- Arithmetic: count never exceeds WINSIZE; no wrap possible.

## Timing

- Reset values: in_ready=1 (IDLE), out_valid=0, out_idx=0, out_last=0, done=0, count=0, busy=0; vec_reg=0.
- Input handshake at cycle T -> out_valid at T+1 with first index.
- out_ready held high: N set bits emitted on N consecutive cycles T+1..T+N.
- Last handshake at cycle L -> done=1, count=N, in_ready=1 at L+1; a new window may be accepted at L+1 (window period N+1 cycles).
- Zero vector accepted at T -> done=1, count=0 at T+1; in_ready stays high throughout.
- Backpressure: while out_valid&&!out_ready, out_idx, out_last, vec_reg held stable.
- rst mid-scan: all state returns to reset values next cycle; no done pulse.

## Configuration

- SCAN_REVERSE_EN defined: encoder input is bit-reversed and result mapped back (WINSIZE-1-enc), so indices emit highest-first; out_last still marks the final emitted bit.
- Not defined: indices emit in ascending order (lowest set bit first).

## Test plan

- in_vec bits {3,77,199}, out_ready=1 -> out_idx 3,77,199 on consecutive cycles, out_last only with 199, done next cycle with count=3.
- Same vector, out_ready toggled 1-0-0-1-1 -> each index held while stalled, same order, count=3, no duplicates or drops.
- in_vec=0 -> no out_valid, done one cycle after handshake, count=0, in_ready never drops.
- Single bit 0, then single bit 199 back-to-back (in_valid held) -> idx 0 with out_last, done; second window accepted at done cycle, idx 199 with out_last, count=1 each.
- All 200 bits set, flush asserted after 10 handshakes -> IDLE next cycle, out_valid=0, count=0, no done; fresh window then processes normally.
- SCAN_REVERSE_EN defined, bits {3,77,199} -> 199,77,3, out_last with 3, count=3.
